// File: rtl/camera_commit_regs.sv
// camera_commit_regs: double-buffered camera register bank.
// Camera writes land in shadow registers at any time. On the frame-end pixel,
// all dirty fields are committed to the active camera at once, so a frame is
// never rendered with a half-updated camera. The block also produces the
// per-frame overwrite flag for the frame buffer.
module camera_commit_regs #(
  parameter int unsigned H_LAST       = 1279,
  parameter int unsigned V_LAST       = 719,
  parameter logic [71:0] ORIGIN_INIT  = 72'h0,
  parameter logic [71:0] FORWARD_INIT = {24'h0, 24'h0, 24'h484000},
  parameter logic [71:0] RIGHT_INIT   = {24'h3f0000, 24'h0, 24'h0},
  parameter logic [71:0] UP_INIT      = {24'h0, 24'h3f0000, 24'h0}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flash_wen,
  input  logic [7:0]  flash_cmd,
  input  logic [71:0] flash_cam_data,
  input  logic        ray_done,
  input  logic [10:0] pixel_h,
  input  logic [9:0]  pixel_v,
  input  logic        force_overwrite,
  output logic [71:0] cam_origin,
  output logic [71:0] cam_forward,
  output logic [71:0] cam_right,
  output logic [71:0] cam_up,
  output logic        overwrite,
  output logic        pending,
  output logic        commit_pulse,
  output logic [7:0]  commit_count
);

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_e;

  localparam logic [10:0] H_LAST_C = 11'(H_LAST);
  localparam logic [9:0]  V_LAST_C = 10'(V_LAST);

  // Field index: 0 origin, 1 forward, 2 right, 3 up.
  localparam logic [3:0][71:0] FIELD_INIT = {UP_INIT, RIGHT_INIT, FORWARD_INIT, ORIGIN_INIT};

  state_e            state_q, state_d;
  logic [3:0]        dirty_q, dirty_d;
  logic [3:0][71:0]  shadow_q, shadow_d;
  logic [3:0][71:0]  active_q, active_d;
  logic              overwrite_q, overwrite_d;
  logic              commit_pulse_q, commit_pulse_d;
  logic [7:0]        commit_count_q, commit_count_d;

  logic              wr_valid;
  logic [1:0]        wr_sel;
  logic              frame_end;
  logic              commit;

  assign wr_valid  = flash_wen & flash_cmd[7];
  assign wr_sel    = flash_cmd[1:0];
  // Pixel coordinates only mean something while ray_done is high.
  assign frame_end = ray_done && (pixel_h == H_LAST_C) && (pixel_v == V_LAST_C);

  // Next-state logic: shadow capture, commit decision and frame flags.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d        = state_q;
    dirty_d        = dirty_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    overwrite_d    = overwrite_q;
    commit_pulse_d = 1'b0;
    commit_count_d = commit_count_q;
    commit         = 1'b0;

    if (wr_valid) begin
      shadow_d[wr_sel] = flash_cam_data;
    end

    if (frame_end) begin
      overwrite_d = force_overwrite | (state_q == ST_PENDING) | wr_valid;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_valid) begin
          if (frame_end) commit = 1'b1;   // write lands straight in active
          else           state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_end) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        // A same-cycle write is forwarded; otherwise only dirty fields move.
        if (wr_valid && (wr_sel == 2'(i))) active_d[i] = flash_cam_data;
        else if (dirty_q[i])               active_d[i] = shadow_q[i];
      end
      dirty_d        = '0;
      commit_pulse_d = 1'b1;
      commit_count_d = commit_count_q + 8'd1;
    end else if (wr_valid) begin
      dirty_d[wr_sel] = 1'b1;
    end
  end

  // State and register bank update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      dirty_q        <= '0;
      // NOTE: both camera banks are reset on purpose: rtx needs a valid camera from the first frame.
      shadow_q       <= FIELD_INIT;
      active_q       <= FIELD_INIT;
      overwrite_q    <= 1'b1;
      commit_pulse_q <= 1'b0;
      commit_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q        <= state_d;
      dirty_q        <= dirty_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      overwrite_q    <= overwrite_d;
      commit_pulse_q <= commit_pulse_d;
      commit_count_q <= commit_count_d;
    end
  end

  assign cam_origin   = active_q[0];
  assign cam_forward  = active_q[1];
  assign cam_right    = active_q[2];
  assign cam_up       = active_q[3];
  assign overwrite    = overwrite_q;
  assign pending      = (state_q == ST_PENDING);
  assign commit_pulse = commit_pulse_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_camera_commit_regs.sv
// Self-checking bench for camera_commit_regs: directed scenarios with literal
// expectations plus a randomized phase, all compared against a frame-level
// model of the camera (shadow copy, dirty set, commit = active takes shadow).
module tb_camera_commit_regs;

  localparam logic [71:0] ORIGIN_INIT  = 72'h0;
  localparam logic [71:0] FORWARD_INIT = 72'h000000_000000_484000;
  localparam logic [71:0] RIGHT_INIT   = 72'h3f0000_000000_000000;
  localparam logic [71:0] UP_INIT      = 72'h000000_3f0000_000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flash_wen = 1'b0;
  logic [7:0]  flash_cmd = '0;
  logic [71:0] flash_cam_data = '0;
  logic        ray_done = 1'b0;
  logic [10:0] pixel_h = '0;
  logic [9:0]  pixel_v = '0;
  logic        force_overwrite = 1'b0;
  logic [71:0] cam_origin, cam_forward, cam_right, cam_up;
  logic        overwrite, pending, commit_pulse;
  logic [7:0]  commit_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  camera_commit_regs dut (
    .clk(clk), .rst(rst),
    .flash_wen(flash_wen), .flash_cmd(flash_cmd), .flash_cam_data(flash_cam_data),
    .ray_done(ray_done), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .force_overwrite(force_overwrite),
    .cam_origin(cam_origin), .cam_forward(cam_forward), .cam_right(cam_right), .cam_up(cam_up),
    .overwrite(overwrite), .pending(pending), .commit_pulse(commit_pulse),
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [71:0] m_active [4];
  logic [71:0] m_shadow [4];
  logic [3:0]  m_dirty;
  logic        m_ow, m_pulse;
  logic [7:0]  m_count;

  logic tb_wr, tb_fe, tb_commit;
  assign tb_wr     = flash_wen && flash_cmd[7];
  assign tb_fe     = ray_done && (pixel_h == 11'd1279) && (pixel_v == 10'd719);
  assign tb_commit = tb_fe && ((m_dirty != 4'd0) || tb_wr);

  // Shadow content of field i once this cycle's write (if any) is applied.
  function automatic logic [71:0] after_write(input int i);
    return (tb_wr && (flash_cmd[1:0] == 2'(i))) ? flash_cam_data : m_shadow[i];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= '{ORIGIN_INIT, FORWARD_INIT, RIGHT_INIT, UP_INIT};
      m_shadow <= '{ORIGIN_INIT, FORWARD_INIT, RIGHT_INIT, UP_INIT};
      m_dirty  <= '0;
      m_ow     <= 1'b1;
      m_pulse  <= 1'b0;
      m_count  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] <= after_write(i);
        // Clean fields already match shadow, so a commit copies the whole shadow.
        if (tb_commit) m_active[i] <= after_write(i);
      end
      if (tb_fe) m_ow <= force_overwrite | (m_dirty != 4'd0) | tb_wr;
      m_pulse <= tb_commit;
      if (tb_commit) begin
        m_count <= m_count + 8'd1;
        m_dirty <= '0;
      end else if (tb_wr) begin
        m_dirty[flash_cmd[1:0]] <= 1'b1;
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cam_origin",   cam_origin,   m_active[0]);
      check("cam_forward",  cam_forward,  m_active[1]);
      check("cam_right",    cam_right,    m_active[2]);
      check("cam_up",       cam_up,       m_active[3]);
      check("overwrite",    72'(overwrite),    72'(m_ow));
      check("pending",      72'(pending),      72'(m_dirty != 4'd0));
      check("commit_pulse", 72'(commit_pulse), 72'(m_pulse));
      check("commit_count", 72'(commit_count), 72'(m_count));
    end
  end

  // Drive one cycle of stimulus; returns 1 time unit after the sampling edge.
  task automatic cyc(input logic wen, input logic [7:0] cmd, input logic [71:0] d,
                     input logic rd, input logic [10:0] h, input logic [9:0] v);
    @(negedge clk);
    flash_wen = wen; flash_cmd = cmd; flash_cam_data = d;
    ray_done = rd; pixel_h = h; pixel_v = v;
    @(posedge clk);
    #1;
    flash_wen = 1'b0; ray_done = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 72'h0, 1'b0, 11'd0, 10'd0);
  endtask

  task automatic fe();
    cyc(1'b0, 8'h00, 72'h0, 1'b1, 11'd1279, 10'd719);
  endtask

  localparam logic [71:0] DATA_A = 72'h111111_222222_333333;
  localparam logic [71:0] DATA_B = 72'hAAAAAA_BBBBBB_CCCCCC;
  localparam logic [71:0] DATA_C = 72'h123456_789ABC_DEF012;
  localparam logic [71:0] DATA_D = 72'hFEDCBA_987654_321000;

  initial begin
    // Asynchronous reset asserted mid-clock; values must appear before any edge.
    #13 rst = 1'b1;
    #1;
    check("rst_forward",  cam_forward, FORWARD_INIT);
    check("rst_overwrite", 72'(overwrite), 72'h1);
    check("rst_pending",  72'(pending), 72'h0);
    check("rst_count",    72'(commit_count), 72'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Single commit.
    cyc(1'b1, 8'h80, 72'h1, 1'b1, 11'd100, 10'd5);
    check("single_pending", 72'(pending), 72'h1);
    check("single_origin_hold", cam_origin, 72'h0);
    idle(); idle();
    check("single_origin_hold2", cam_origin, 72'h0);
    fe();
    check("single_origin", cam_origin, 72'h1);
    check("single_pulse", 72'(commit_pulse), 72'h1);
    check("single_count", 72'(commit_count), 72'h1);
    check("single_overwrite", 72'(overwrite), 72'h1);
    check("single_pending_clr", 72'(pending), 72'h0);
    idle();
    check("single_pulse_drop", 72'(commit_pulse), 72'h0);

    // Same-field overwrite within one frame.
    cyc(1'b1, 8'h81, DATA_A, 1'b0, 11'd0, 10'd0);
    cyc(1'b1, 8'h81, DATA_B, 1'b0, 11'd0, 10'd0);
    check("same_forward_hold", cam_forward, FORWARD_INIT);
    fe();
    check("same_forward", cam_forward, DATA_B);
    check("same_count", 72'(commit_count), 72'h2);

    // Write coincident with frame end, from the idle state.
    idle();
    cyc(1'b1, 8'h83, DATA_C, 1'b1, 11'd1279, 10'd719);
    check("coinc_up", cam_up, DATA_C);
    check("coinc_pulse", 72'(commit_pulse), 72'h1);
    check("coinc_pending", 72'(pending), 72'h0);
    check("coinc_count", 72'(commit_count), 72'h3);

    // Quiet frame, ignored command, forced overwrite.
    force_overwrite = 1'b0;
    idle();
    fe();
    check("quiet_overwrite", 72'(overwrite), 72'h0);
    check("quiet_pulse", 72'(commit_pulse), 72'h0);
    check("quiet_count", 72'(commit_count), 72'h3);
    cyc(1'b1, 8'h03, DATA_D, 1'b0, 11'd0, 10'd0);
    check("ignored_pending", 72'(pending), 72'h0);
    fe();
    check("ignored_up", cam_up, DATA_C);
    check("ignored_pulse", 72'(commit_pulse), 72'h0);
    check("ignored_overwrite", 72'(overwrite), 72'h0);
    force_overwrite = 1'b1;
    fe();
    check("force_overwrite", 72'(overwrite), 72'h1);
    check("force_count", 72'(commit_count), 72'h3);
    force_overwrite = 1'b0;

    // Reset mid-frame discards the pending write.
    cyc(1'b1, 8'h82, DATA_D, 1'b0, 11'd0, 10'd0);
    check("midrst_pending_before", 72'(pending), 72'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst_origin", cam_origin, ORIGIN_INIT);
    check("midrst_forward", cam_forward, FORWARD_INIT);
    check("midrst_right", cam_right, RIGHT_INIT);
    check("midrst_up", cam_up, UP_INIT);
    check("midrst_pending", 72'(pending), 72'h0);
    @(negedge clk);
    rst = 1'b0;
    fe();
    check("midrst_fe_pulse", 72'(commit_pulse), 72'h0);
    check("midrst_fe_count", 72'(commit_count), 72'h0);
    check("midrst_fe_right", cam_right, RIGHT_INIT);
    check("midrst_fe_overwrite", 72'(overwrite), 72'h0);

    // Randomized phase: writes, near-miss pixels, frame ends, forced overwrite.
    for (int n = 0; n < 4000; n++) begin
      logic [71:0] d;
      logic [10:0] h;
      logic [9:0]  v;
      int          sel;
      d   = {$urandom(), $urandom(), 8'($urandom())};
      sel = int'($urandom_range(0, 5));
      h   = 11'($urandom_range(0, 2047));
      v   = 10'($urandom_range(0, 1023));
      if (sel == 0)      begin h = 11'd1279; v = 10'd719; end
      else if (sel == 1) begin h = 11'd1279; v = 10'd718; end
      else if (sel == 2) begin h = 11'd1278; v = 10'd719; end
      if ($urandom_range(0, 15) == 0) force_overwrite = ~force_overwrite;
      cyc(1'($urandom_range(0, 2) == 0), 8'($urandom()), d,
          1'($urandom_range(0, 3) != 0), h, v);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera_commit_regs.md
# camera_commit_regs

Double-buffered camera register bank between the UART memflash command decoder and the `rtx` core, in the `clk_rtx` domain. Captures camera-vector writes into shadow registers at any time, then commits all pending fields atomically to the active camera on the frame-end pixel. This ensures no frame is rendered with a half-updated camera. It also generates the per-frame `overwrite` flag consumed by `high_definition_frame_buffer`.

## Interface

Parameters:
- `H_LAST`, default 1279: h index of the last pixel of a frame.
- `V_LAST`, default 719: v index of the last pixel of a frame.
- `ORIGIN_INIT`, default 72'h0: reset value of the origin field.
- `FORWARD_INIT`, default {24'h0, 24'h0, 24'h484000}: reset value of the forward field.
- `RIGHT_INIT`, default {24'h3f0000, 24'h0, 24'h0}: reset value of the right field.
- `UP_INIT`, default {24'h0, 24'h3f0000, 24'h0}: reset value of the up field.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: `clk_rtx`.
- `rst`, input, 1: asynchronous, active-high reset.
- `flash_wen`, input, 1: camera write strobe from memflash.
- `flash_cmd`, input, 8: command byte. A write is a camera write only when bit 7 is 1. Bits [1:0] select the field: 0 origin, 1 forward, 2 right, 3 up.
- `flash_cam_data`, input, 72: field value, three 24-bit components {x, y, z}.
- `ray_done`, input, 1: rtx pixel valid.
- `pixel_h`, input, 11: h index of the rtx pixel.
- `pixel_v`, input, 10: v index of the rtx pixel.
- `force_overwrite`, input, 1: switch-driven request to overwrite every frame.
- `cam_origin`, output, 72: active origin field, fed to rtx.
- `cam_forward`, output, 72: active forward field, fed to rtx.
- `cam_right`, output, 72: active right field, fed to rtx.
- `cam_up`, output, 72: active up field, fed to rtx.
- `overwrite`, output, 1: per-frame overwrite flag for the frame buffer.
- `pending`, output, 1: at least one shadow field differs from the active camera (not yet committed).
- `commit_pulse`, output, 1: single-cycle strobe on each commit.
- `commit_count`, output, 8: number of commits, wraps modulo 256.

## Operation

- **Valid write:** `flash_wen` = 1 and `flash_cmd[7]` = 1. The selected shadow field is loaded with `flash_cam_data`, and that field's dirty bit is set. Writes with `flash_cmd[7]` = 0 are ignored entirely and do not mark anything dirty.
- **Frame end (FE):** `ray_done` = 1, `pixel_h` = `H_LAST`, and `pixel_v` = `V_LAST`.
- **FSM states:**
  - IDLE: no dirty bits set.
  - PENDING: one or more dirty bits set.
  - Transitions:
    - IDLE to PENDING on a valid write without FE.
    - PENDING to IDLE on FE.
    - IDLE stays IDLE on FE with a simultaneous valid write; the write is committed immediately.
- **Commit on FE when PENDING, or when a valid write coincides with FE:**
  - Each dirty field is copied from shadow to active.
  - A write arriving in the same cycle is forwarded, so its data reaches active directly.
  - All dirty bits are cleared.
  - `commit_pulse` is asserted and `commit_count` increments.
- **Clean fields:** never rewritten. Active always equals shadow for clean fields.
- **Same-field writes in one frame:** the last write wins; only one commit occurs.
- **`overwrite`:** updated only on FE, to `force_overwrite` OR `pending` OR (valid write this cycle). Held for the whole following frame.
- **FE without a commit:** no commit pulse and no count change. `overwrite` still updates.
- **Reset:**
  - Active and shadow fields load their `*_INIT` values.
  - Dirty bits clear; state goes to IDLE.
  - `overwrite` = 1, so the first frame is written.
  - `pending` = 0, `commit_pulse` = 0, `commit_count` = 0.
  - Reset asserted mid-frame discards uncommitted writes.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Shadow update: valid write at cycle N, shadow updated at N+1. `pending` = 1 at N+1 unless FE occurs at N.
- Commit: FE at cycle N gives `cam_*` updated, `commit_pulse` = 1, `commit_count` incremented, and `overwrite` updated, all at N+1. `commit_pulse` returns to 0 at N+2 unless another FE occurs.
- `cam_*` are stable on every cycle other than the cycle after FE.
- Back-to-back writes on consecutive cycles are all accepted; there is no backpressure.
- `pixel_h` and `pixel_v` are ignored when `ray_done` = 0.

## Test plan

- **Reset values:** Assert `rst` asynchronously mid-clock. Expect `cam_forward` = 72'h000000_000000_484000, `overwrite` = 1, `pending` = 0, and `commit_count` = 0, all without waiting for a clock edge.
- **Single commit:** Write cmd 8'h80 with data 72'h1 at pixel (100, 5). Expect `pending` = 1 next cycle and `cam_origin` unchanged until FE at (1279, 719). The cycle after FE: `cam_origin` = 72'h1, `commit_pulse` = 1, `commit_count` = 1, `overwrite` = 1, `pending` = 0.
- **Same-field overwrite:** Write cmd 8'h81 with data A, then 8'h81 with data B, in the same frame. Expect `cam_forward` = B after FE and a single `commit_count` increment.
- **Write coincident with FE:** Issue a valid write with cmd 8'h83 in the FE cycle. Expect `cam_up` updated the next cycle, `commit_pulse` = 1, and `pending` = 0.
- **Quiet frame and ignored command:**
  - Frame with no writes and `force_overwrite` = 0: after FE, `overwrite` = 0 and no commit pulse.
  - Write with cmd 8'h03 (bit 7 = 0): no state change at all.
  - Frame with no writes and `force_overwrite` = 1: after FE, `overwrite` = 1.
- **Reset mid-frame:** After a pending write, assert `rst` before FE. Expect all fields at their INIT values and `pending` = 0. A following FE produces no commit.
